// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multicycle ALU.
//   - opcode encodings (the low ones match the older combinational ALU)
//   - FSM state type
//   - helper telling which opcodes take the iterative path
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_DIVU = 4'b1001;
    localparam logic [3:0] ALU_REMU = 4'b1010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle multiply / unsigned divide engine.
//   clk, reset : clock, async active-high reset
//   start      : load operands and mode, begin WIDTH iterations
//   abort      : drop the in-flight operation (counter cleared)
//   op         : opcode sampled at start (MUL, DIVU or REMU)
//   a, b       : operands sampled at start
//   done       : high during the cycle of the last iteration
//   res        : final result, valid together with done (combinational
//                from the last step, so the caller registers it that edge)
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // acc  : product (MUL) or partial remainder (DIV)
    // opnd : multiplicand shifted left (MUL) or fixed divisor (DIV)
    // shreg: multiplier shifted right (MUL) or dividend-in / quotient-out (DIV)
    logic [WIDTH-1:0] acc, opnd, shreg;
    logic [CNT_W-1:0] cnt;
    logic             is_mul, is_rem;

    logic [WIDTH-1:0] acc_nx, opnd_nx, shreg_nx;
    logic [WIDTH:0]   r_sh, trial;

    always_comb begin
        r_sh     = {acc, shreg[WIDTH-1]};
        trial    = r_sh - {1'b0, opnd};
        acc_nx   = acc;
        opnd_nx  = opnd;
        shreg_nx = shreg;
        if (is_mul) begin
            acc_nx   = shreg[0] ? acc + opnd : acc;
            opnd_nx  = opnd << 1;
            shreg_nx = shreg >> 1;
        end else if (!trial[WIDTH]) begin
            // trial subtraction fits: keep it and shift in a 1 quotient bit
            acc_nx   = trial[WIDTH-1:0];
            shreg_nx = {shreg[WIDTH-2:0], 1'b1};
        end else begin
            acc_nx   = r_sh[WIDTH-1:0];
            shreg_nx = {shreg[WIDTH-2:0], 1'b0};
        end
    end

    // Divide by zero falls out naturally: every trial succeeds, so the
    // quotient is all ones and the remainder collects the dividend bits.
    assign done = (cnt == CNT_W'(1));
    assign res  = (is_mul || is_rem) ? acc_nx : shreg_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            opnd   <= '0;
            shreg  <= '0;
            cnt    <= '0;
            is_mul <= 1'b0;
            is_rem <= 1'b0;
        end else if (abort) begin
            cnt <= '0;
        end else if (start) begin
            acc    <= '0;
            opnd   <= (op == ALU_MUL) ? a : b;
            shreg  <= (op == ALU_MUL) ? b : a;
            cnt    <= CNT_W'(WIDTH);
            is_mul <= (op == ALU_MUL);
            is_rem <= (op == ALU_REMU);
        end else if (cnt != '0) begin
            acc   <= acc_nx;
            opnd  <= opnd_nx;
            shreg <= shreg_nx;
            cnt   <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multicycle ALU with valid/ready handshake.
//   clk, reset          : clock, async active-high reset
//   in_valid / in_ready : operation offer / accept (ready only in IDLE)
//   a, b, ALUOp         : operands and opcode, sampled at accept
//   kill                : abort in-flight op (BUSY/DONE); blocks accept in IDLE
//   out_valid/out_ready : result hand-off (valid only in DONE)
//   Result, zero, Less  : registered result and flags
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUOp,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             zero,
    output logic             Less
);
    alu_state_t       state, state_nx;
    logic [WIDTH-1:0] sc_res, res_d, it_res;
    logic             slt, less_d, load, start, it_done;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (kill && (state == BUSY)),
        .op    (ALUOp),
        .a     (a),
        .b     (b),
        .done  (it_done),
        .res   (it_res)
    );

    // single-cycle datapath, straight from the accept-cycle operands
    always_comb begin
        slt = ($signed(a) < $signed(b));
        case (ALUOp)
            ALU_AND: sc_res = a & b;
            ALU_OR:  sc_res = a | b;
            ALU_ADD: sc_res = a + b;
            ALU_SUB: sc_res = a - b;
            ALU_SLT: sc_res = {{(WIDTH-1){1'b0}}, slt};
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        load     = 1'b0;
        res_d    = sc_res;
        less_d   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && !kill) begin
                    if (is_iter(ALUOp)) begin
                        start    = 1'b1;
                        state_nx = BUSY;
                    end else begin
                        load     = 1'b1;
                        // SLT reports the compare outcome, not bit WIDTH-1
                        less_d   = (ALUOp == ALU_SLT) ? slt : sc_res[WIDTH-1];
                        state_nx = DONE;
                    end
                end
            end
            BUSY: begin
                if (kill) begin
                    state_nx = IDLE;
                end else if (it_done) begin
                    load     = 1'b1;
                    res_d    = it_res;
                    less_d   = it_res[WIDTH-1];
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (kill || out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            Result <= '0;
            zero   <= 1'b1;
            Less   <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                Result <= res_d;
                zero   <= (res_d == '0);
                Less   <= less_d;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 64;
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_MUL = 4'b1000,
                           OP_DIVU = 4'b1001, OP_REMU = 4'b1010, OP_BAD = 4'b0011;

    logic         clk = 1'b0;
    logic         reset, in_valid, kill, out_ready;
    logic [W-1:0] a, b;
    logic [3:0]   op;
    logic         in_ready, out_valid, zero, Less;
    logic [W-1:0] Result;

    int compared = 0, mismatched = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUOp(op), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .zero(zero), .Less(Less)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: plain arithmetic on the opcode meaning
    function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_SLT:  return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            OP_MUL:  return x * y;
            OP_DIVU: return (y == 0) ? {W{1'b1}} : x / y;
            OP_REMU: return (y == 0) ? x : x % y;
            default: return '0;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] o);
        return (o == OP_MUL || o == OP_DIVU || o == OP_REMU) ? W + 1 : 1;
    endfunction

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        chk("ready_before_issue", W'(in_ready), W'(1));
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit release_now);
        logic [W-1:0] e;
        int lat;
        e = model(o, x, y);
        issue(o, x, y);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            chk("ready_low_busy", W'(in_ready), W'(0));
            @(negedge clk);
            lat++;
        end
        chk("latency", W'(lat), W'(latency(o)));
        chk("result", Result, e);
        chk("zero", W'(zero), W'(e == 0));
        chk("less", W'(Less), W'((o == OP_SLT) ? e[0] : e[W-1]));
        if (release_now) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk("idle_after_handoff", W'({in_ready, out_valid}), W'(2'b10));
        end
    endtask

    initial begin
        logic [W-1:0] held;
        logic [3:0]   ops [9];
        bit           seen;
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MUL, OP_DIVU, OP_REMU, OP_BAD};
        reset = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_result", Result, '0);
        chk("rst_flags", W'({zero, Less}), W'(2'b10));
        reset = 1'b0;

        // directed cases
        run_op(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1);
        run_op(OP_SUB, 64'd5, 64'd5, 1);
        run_op(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1);
        run_op(OP_DIVU, 64'd100, 64'd7, 1);
        run_op(OP_REMU, 64'd100, 64'd7, 1);
        run_op(OP_DIVU, 64'd9, 64'd0, 1);
        run_op(OP_REMU, 64'd9, 64'd0, 1);
        run_op(OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1);
        run_op(OP_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op(OP_BAD, 64'd12, 64'd34, 1);

        // back-pressure: result held, new offer refused
        run_op(OP_OR, 64'h1234, 64'h8000_0000_0000_0000, 0);
        held = Result;
        op = OP_ADD; a = 64'd1; b = 64'd1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_result_stable", Result, held);
            chk("bp_valid_ready", W'({out_valid, in_ready}), W'(2'b10));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_idle", W'({in_ready, out_valid}), W'(2'b10));

        // kill mid-DIVU
        issue(OP_DIVU, 64'd1000, 64'd3);
        repeat (29) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy_idle", W'({in_ready, out_valid}), W'(2'b10));
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("kill_no_valid", W'(seen), W'(0));
        run_op(OP_AND, 64'hF0, 64'h3C, 1);

        // kill in IDLE blocks the offer
        @(negedge clk);
        op = OP_ADD; a = 64'd2; b = 64'd3; in_valid = 1'b1; kill = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; kill = 1'b0;
        chk("kill_idle_no_accept", W'({in_ready, out_valid}), W'(2'b10));

        // kill wins over out_ready in DONE
        run_op(OP_ADD, 64'd40, 64'd2, 0);
        kill = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        kill = 1'b0; out_ready = 1'b0;
        chk("kill_done_idle", W'({in_ready, out_valid}), W'(2'b10));

        // reset mid-BUSY (previous Result is non-zero)
        issue(OP_MUL, 64'd7, 64'd9);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_busy_ready_valid", W'({in_ready, out_valid}), W'(2'b10));
        chk("rst_busy_result", Result, '0);
        chk("rst_busy_flags", W'({zero, Less}), W'(2'b10));
        @(negedge clk);
        reset = 1'b0;

        // randomized operations against the model
        for (int n = 0; n < 40; n++) begin
            logic [3:0]   o;
            logic [W-1:0] x, y;
            o = ops[$urandom_range(0, 8)];
            x = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       y = '0;
                1:       y = W'($urandom_range(1, 50));
                2:       y = W'($urandom);
                default: y = {$urandom, $urandom};
            endcase
            run_op(o, x, y, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multicycle ALU: successor to the 64-bit combinational ALU, generalised in operand width and extended with iterative multiply, unsigned divide and remainder behind a valid/ready handshake. Sits in the execute stage of the pipelined RISC-V core. The stage issues one operation and stalls on `in_ready` low, then consumes the registered result and flags.

## Interface
Parameters:
- `WIDTH`, 64: operand/result width; any value ≥ 8.
- `CNT_W`, `$clog2(WIDTH+1)` (localparam): iteration counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: block can accept (IDLE only).
- `a`, `b` in WIDTH: operands, sampled at accept.
- `ALUOp` in 4: operation code, sampled at accept.
- `kill` in 1: synchronous abort of the in-flight op.
- `out_valid` out 1: `Result`/`zero`/`Less` valid.
- `out_ready` in 1: consumer takes result.
- `Result` out WIDTH: registered result.
- `zero` out 1: 1 iff `Result == 0`.
- `Less` out 1: `Result[WIDTH-1]`. For SLT, equals the compare outcome.

## Operation
- Opcodes:
  - `0000` AND, `0001` OR, `0010` ADD, `0110` SUB: encodings kept from the previous ALU.
  - `0111` SLT: signed; result is 1 or 0.
  - `1000` MUL: low WIDTH bits of the product.
  - `1001` DIVU: quotient.
  - `1010` REMU: remainder.
  - Any other code: `Result`=0, `zero`=1, `Less`=0; single-cycle path.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- Divide by zero: DIVU gives all ones; REMU gives `a`. No trap.
- MUL: shift-add, one bit per cycle, LSB of multiplier first.
- DIVU/REMU: restoring division, one quotient bit per cycle, MSB first.
- FSM, states IDLE, BUSY, DONE:
  - IDLE: `in_ready`=1. On `in_valid`, latch `a`, `b` and `ALUOp`.
    - Single-cycle op: compute, register the result, go to DONE.
    - MUL/DIVU/REMU: load the counter with WIDTH, go to BUSY.
  - BUSY: one iteration per cycle, counter decrements. When the counter reaches 0 after the last iteration, register the result and go to DONE.
  - DONE: `out_valid`=1, outputs held stable. When `out_ready`=1, go to IDLE.
- `kill`:
  - In BUSY or DONE: go to IDLE next edge and drop the result; `out_valid` low next cycle.
  - In IDLE: ignored, and any `in_valid` that cycle is not accepted.
  - `kill` overrides `out_ready` when both are high.
- Reset: state IDLE, `in_ready`=1, `out_valid`=0, `Result`=0, `zero`=1, `Less`=0, counter 0. Reset mid-operation discards all state.

## Timing
- Accept: the edge where `in_valid && in_ready`.
- Latency, accept edge to first `out_valid` cycle:
  - Single-cycle ops: 1 cycle.
  - MUL/DIVU/REMU: WIDTH+1 cycles (65 at WIDTH=64).
- Outputs change only on the edge entering DONE or on reset. They hold their last value in IDLE/BUSY, but are only meaningful while `out_valid`=1.
- Throughput: no accept in the same cycle as result hand-off. Max one single-cycle op every 2 cycles; one MUL/DIV every WIDTH+2 cycles.
- `in_ready` is a pure function of state, with no combinational path from `in_valid`/`out_ready`.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_MUL`, `ALU_DIVU`, `ALU_REMU`;
  - state enum `alu_state_t` {IDLE, BUSY, DONE}.
- Sub-module `alu_muldiv_iter`:
  - holds the shared accumulator, the shifted operand registers and the counter;
  - handles MUL and DIVU/REMU under `start`/`done`.
- The top level keeps the FSM, the single-cycle datapath, the flag generation and the handshake.

## Test plan
- Reset asserted mid-BUSY → next cycle `in_ready`=1, `out_valid`=0, `Result`=0, `zero`=1, `Less`=0.
- WIDTH=64, ADD a=`0x7FFF_FFFF_FFFF_FFFF`, b=1 → after 1 cycle `Result`=`0x8000_0000_0000_0000`, `Less`=1, `zero`=0. SUB a=5, b=5 → `Result`=0, `zero`=1.
- MUL a=`0xFFFF_FFFF_FFFF_FFFF`, b=3 → `out_valid` exactly 65 cycles after accept, `Result`=`0xFFFF_FFFF_FFFF_FFFD`. `in_ready` stays low throughout.
- DIVU a=100, b=7 → `Result`=14. REMU a=100, b=7 → 2. DIVU a=9, b=0 → all ones. REMU a=9, b=0 → 9.
- Back-pressure: `out_ready` held low 10 cycles in DONE → `Result` stable and `in_valid` not accepted. On `out_ready`=1, IDLE next cycle.
- `kill` on cycle 30 of a DIVU → IDLE next cycle, no `out_valid`. A following AND a=`0xF0`, b=`0x3C` → `Result`=`0x30`.
